// File: rtl/timer_bank.sv
// timer_bank: NCH independent cyclic/one-shot timers sharing one prescaler.
//   clk, rst (async, active-high)
//   cnt_acc   [NCH*WIDTH] per-channel preset, channel i at [i*WIDTH +: WIDTH]
//   mode      [NCH] 1 = cyclic (level start), 0 = one-shot (rising-edge start)
//   cnt_start [NCH] per-channel start control
//   psc       [PSC_W] shared prescaler, one tick every psc+1 clocks
//   count_now [NCH*WIDTH] per-channel current count
//   full_r    [NCH] registered one-clock terminal pulse
//   busy      [NCH] channel running
//   tone      [NCH] toggles on every terminal event
module timer_bank #(
  parameter int WIDTH = 32,
  parameter int NCH = 4,
  parameter int PSC_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] cnt_acc,
  input  logic [NCH-1:0]       mode,
  input  logic [NCH-1:0]       cnt_start,
  input  logic [PSC_W-1:0]     psc,
  output logic [NCH*WIDTH-1:0] count_now,
  output logic [NCH-1:0]       full_r,
  output logic [NCH-1:0]       busy,
  output logic [NCH-1:0]       tone
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN_CYC = 2'd1;
  localparam logic [1:0] RUN_ONE = 2'd2;
  logic [PSC_W-1:0] psc_q;
  logic tick;
  assign tick = psc_q == psc;
  // >= rather than == so a psc lowered below the running count wraps at once
  always_ff @(posedge clk or posedge rst)
    if (rst) psc_q <= '0;
    else psc_q <= psc_q >= psc ? '0 : psc_q + 1'b1;
  genvar i;
  generate
    for (i = 0; i < NCH; i++) begin : g_ch
      logic [1:0] state;
      logic [WIDTH-1:0] acc_q, count, acc_in;
      logic start_q, full_q, tone_q, run, go, term;
      assign acc_in = cnt_acc[i*WIDTH +: WIDTH];
      assign run = state != IDLE;
      // start_q resets to 0, so a level held through reset reads as a fresh edge
      assign go = acc_in != '0 && cnt_start[i] && (mode[i] || !start_q);
      assign term = run && tick && count == acc_q - 1'b1;
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          state <= IDLE;
          acc_q <= '0;
          count <= '0;
          start_q <= 1'b0;
          full_q <= 1'b0;
          tone_q <= 1'b0;
        end else begin
          start_q <= cnt_start[i];
          full_q <= term;
          if (term) begin
            count <= '0;
            tone_q <= ~tone_q;
            acc_q <= acc_in;
            state <= state == RUN_CYC && cnt_start[i] && acc_in != '0 ? RUN_CYC : IDLE;
          end else if (state == IDLE) begin
            if (go) begin
              acc_q <= acc_in;
              count <= '0;
              state <= mode[i] ? RUN_CYC : RUN_ONE;
            end
          end else if (state == RUN_CYC && !cnt_start[i]) begin
            state <= IDLE;
            count <= '0;
          end else if (tick) count <= count + 1'b1;
        end
      assign count_now[i*WIDTH +: WIDTH] = count;
      assign full_r[i] = full_q;
      assign busy[i] = run;
      assign tone[i] = tone_q;
    end
  endgenerate
endmodule
